// File: rtl/uart_rx_cfg_if.sv
// Receive-side word handshake between uart_rx_cfg (master) and its consumer (slave).
// rx_vld/rx_data/flags are held by the master until a cycle with rx_vld && rx_ready.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx_vld;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_vld, rx_data, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_vld, rx_data, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, 3-sample majority vote per bit, optional parity,
// 1/2 stop bits, break wait after a bad stop, and a held valid/ready output with overrun pulse.
module uart_rx_cfg #(
    parameter int CLK_PER_BIT = 10,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    uart_rx_cfg_if.master        rx_if,
    output logic                 busy,
    output logic [2:0]           state_o
);
    localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 2;
    localparam int BW = 4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] RESOLVE   = CW'(CLK_PER_BIT / 2 + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [BW-1:0]        bit_cnt_q;
    logic [1:0]           smp_q;
    logic                 rxs_prev_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_acc_q;
    logic                 ferr_acc_q;
    logic                 vld_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 ovr_q;

    logic rxs;
    logic resolve_d;
    logic vote_d;
    logic ferr_fin_d;
    logic frame_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    // The vote uses the two previous samples plus the current one, so a bit is
    // resolved once the sample after its mid-point has been seen.
    always_comb begin
        rxs          = sync_q[SYNC_STAGES-1];
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        resolve_d    = (cnt_q == RESOLVE);
        vote_d       = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs) | (smp_q[0] & rxs);
        ferr_fin_d   = ferr_acc_q | ~vote_d;
        frame_done_d = (state_q == S_STOP) && resolve_d && (bit_cnt_q == STOP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= 2'b11;
            rxs_prev_q <= 1'b1;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            smp_q      <= {smp_q[0], rxs};
            rxs_prev_q <= rxs;
            ovr_q      <= 1'b0;
            cnt_q      <= cnt_d;

            if (vld_q && rx_if.rx_ready) begin
                vld_q <= 1'b0;
            end
            // A word still waiting unaccepted wins; the new frame is dropped.
            if (frame_done_d) begin
                if (vld_q && !rx_if.rx_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    vld_q  <= 1'b1;
                    data_q <= shift_q;
                    perr_q <= perr_acc_q;
                    ferr_q <= ferr_fin_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (rxs_prev_q && !rxs) begin
                        state_q <= S_START;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (resolve_d) begin
                        if (vote_d) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_DATA;
                            bit_cnt_q  <= '0;
                            perr_acc_q <= 1'b0;
                            ferr_acc_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (resolve_d) begin
                        shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (resolve_d) begin
                        perr_acc_q <= (^shift_q) ^ vote_d ^ ODD_PAR;
                        bit_cnt_q  <= '0;
                        state_q    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (resolve_d) begin
                        ferr_acc_q <= ferr_fin_d;
                        if (bit_cnt_q == STOP_LAST) begin
                            state_q <= ferr_fin_d ? S_BREAK : S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_if.rx_vld     = vld_q;
    assign rx_if.rx_data    = data_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;
    assign busy             = (state_q != S_IDLE);
    assign state_o          = state_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and an 8E2 instance on separate serial lines,
// checked by per-instance expected queues popped on each accepted word.
module tb_uart_rx_cfg;
  localparam int C    = 10;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic busy0, busy1;
  logic [2:0] st0, st1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();

  uart_rx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx0), .rx_if(if0), .busy(busy0), .state_o(st0)
  );
  uart_rx_cfg #(.CLK_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx1), .rx_if(if1), .busy(busy1), .state_o(st1)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int ov_cnt0 = 0;
  int ov_cnt1 = 0;
  int rise0 = -1;
  int start_cyc = 0;

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // scoreboards
  logic       pv0 = 1'b0, phs0 = 1'b0, pv1 = 1'b0, phs1 = 1'b0;
  logic [7:0] pd0, pd1;
  always @(negedge clk) begin : mon0
    logic [9:0] e;
    if (rst_n) begin
      if (if0.overrun) ov_cnt0++;
      if (if0.rx_vld && !pv0) rise0 = cyc;
      if (pv0 && if0.rx_vld && !phs0) check("hold_data0", {24'd0, if0.rx_data}, {24'd0, pd0});
      if (if0.rx_vld && if0.rx_ready) begin
        if (exp_q0.size() == 0) check("unexpected_vld0", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check("word0", {22'd0, if0.parity_err, if0.frame_err, if0.rx_data}, {22'd0, e});
        end
      end
      pv0 = if0.rx_vld; pd0 = if0.rx_data; phs0 = if0.rx_vld && if0.rx_ready;
    end else begin
      pv0 = 1'b0; phs0 = 1'b0;
    end
  end

  always @(negedge clk) begin : mon1
    logic [9:0] e;
    if (rst_n) begin
      if (if1.overrun) ov_cnt1++;
      if (pv1 && if1.rx_vld && !phs1) check("hold_data1", {24'd0, if1.rx_data}, {24'd0, pd1});
      if (if1.rx_vld && if1.rx_ready) begin
        if (exp_q1.size() == 0) check("unexpected_vld1", 1, 0);
        else begin
          e = exp_q1.pop_front();
          check("word1", {22'd0, if1.parity_err, if1.frame_err, if1.rx_data}, {22'd0, e});
        end
      end
      pv1 = if1.rx_vld; pd1 = if1.rx_data; phs1 = if1.rx_vld && if1.rx_ready;
    end else begin
      pv1 = 1'b0; phs1 = 1'b0;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx0 = b; else rx1 = b;
  endtask

  task automatic send_bit(input int sel, input logic b, input bit glitch);
    set_line(sel, b);
    if (!glitch) tick(C);
    else begin
      tick(C / 2);
      set_line(sel, ~b);
      tick(1);
      set_line(sel, b);
      tick(C - C / 2 - 1);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic bad_par,
                      input logic bad_stop, input int glitch_bit);
    start_cyc = cyc;
    send_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], (i == glitch_bit));
    if (sel == 1) send_bit(sel, (^d) ^ bad_par, 1'b0);
    for (int s = 0; s < ((sel == 1) ? 2 : 1); s++) send_bit(sel, ~bad_stop, 1'b0);
  endtask

  initial begin
    int e_cyc;
    logic [7:0] rd;
    vecs[0] = '{0, 8'h69, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1};

    // reset
    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_vld0", {31'd0, if0.rx_vld}, 0);
    check("rst_data0", {24'd0, if0.rx_data}, 0);
    check("rst_perr0", {31'd0, if0.parity_err}, 0);
    check("rst_ferr0", {31'd0, if0.frame_err}, 0);
    check("rst_ovr0", {31'd0, if0.overrun}, 0);
    check("rst_busy0", {31'd0, busy0}, 0);
    check("rst_vld1", {31'd0, if1.rx_vld}, 0);
    check("rst_data1", {24'd0, if1.rx_data}, 0);
    check("rst_busy1", {31'd0, busy1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(5);

    // 8N1 0x69 with output latency relative to mid-stop
    rise0 = -1;
    exp_q0.push_back({2'b00, 8'h69});
    send(0, 8'h69, 1'b0, 1'b0, -1);
    tick(3);
    e_cyc = start_cyc + SYNC;
    check_rng("t1_vld_latency", rise0, e_cyc + 9 * C + C / 2 + 1, e_cyc + 9 * C + C / 2 + 2);

    // false start: 3 low cycles
    start_cyc = cyc;
    set_line(0, 1'b0);
    tick(3);
    set_line(0, 1'b1);
    e_cyc = start_cyc + SYNC;
    wait_cyc(e_cyc + 2);
    check("fs_busy_hi", {31'd0, busy0}, 1);
    wait_cyc(e_cyc + C / 2);
    check("fs_busy_mid", {31'd0, busy0}, 1);
    wait_cyc(e_cyc + C / 2 + 3);
    check("fs_busy_lo", {31'd0, busy0}, 0);
    tick(C);

    // table vectors
    foreach (vecs[i]) begin
      if (vecs[i].sel == 0) exp_q0.push_back({vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].d});
      else exp_q1.push_back({vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].d});
      send(vecs[i].sel, vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, -1);
      if (vecs[i].bad_stop) begin
        tick(C);
        set_line(vecs[i].sel, 1'b1);
        tick(C);
      end else begin
        tick(3);
      end
    end

    // random good frames on the parity instance
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      exp_q1.push_back({2'b00, rd});
      send(1, rd, 1'b0, 1'b0, -1);
      tick($urandom_range(1, 4));
    end

    // bad stop, line held low 30 cycles: stays in break until line high
    exp_q0.push_back({2'b01, 8'hC3});
    send(0, 8'hC3, 1'b0, 1'b1, -1);
    tick(20);
    @(negedge clk);
    check("brk_busy_low", {31'd0, busy0}, 1);
    @(posedge clk); #1;
    set_line(0, 1'b1);
    tick(SYNC + 3);
    @(negedge clk);
    check("brk_busy_released", {31'd0, busy0}, 0);
    @(posedge clk); #1;
    exp_q0.push_back({2'b00, 8'h3C});
    send(0, 8'h3C, 1'b0, 1'b0, -1);
    tick(3);

    // overrun: consumer stalled across two frames
    if0.rx_ready = 1'b0;
    ov_cnt0 = 0;
    exp_q0.push_back({2'b00, 8'h11});
    send(0, 8'h11, 1'b0, 1'b0, -1);
    tick(2);
    send(0, 8'h22, 1'b0, 1'b0, -1);
    tick(5);
    @(negedge clk);
    check("ovr_vld_held", {31'd0, if0.rx_vld}, 1);
    check("ovr_data_held", {24'd0, if0.rx_data}, 32'h11);
    check("ovr_pulses", ov_cnt0, 1);
    @(posedge clk); #1;
    if0.rx_ready = 1'b1;
    tick(2);
    @(negedge clk);
    check("ovr_vld_dropped", {31'd0, if0.rx_vld}, 0);
    check("ovr_q_empty", exp_q0.size(), 0);
    @(posedge clk); #1;

    // glitch on mid-sample of data bit 3
    exp_q0.push_back({2'b00, 8'h00});
    send(0, 8'h00, 1'b0, 1'b0, 3);
    tick(3);

    // reset during data bit 4 of 0x55
    set_line(0, 1'b0);
    tick(C);
    for (int i = 0; i < 4; i++) send_bit(0, i[0] ? 1'b0 : 1'b1, 1'b0);
    set_line(0, 1'b1);
    tick(C / 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_vld", {31'd0, if0.rx_vld}, 0);
    check("midrst_busy", {31'd0, busy0}, 0);
    @(posedge clk); #1;
    tick(2);
    rst_n = 1'b1;
    tick(3 * C);
    @(negedge clk);
    check("postrst_busy", {31'd0, busy0}, 0);
    check("postrst_vld", {31'd0, if0.rx_vld}, 0);

    // drain with a bound
    for (int i = 0; i < 500 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(negedge clk);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
